// File: rtl/seven_led_pkg.sv
// seven_led_pkg: shared constants, per-digit value record and the
// hex-to-segment table for the multiplexed seven-segment driver.
// Segment patterns are active low: bit 7 = dp, bits 6:0 = g..a.
package seven_led_pkg;

    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam int unsigned SEG_DP_BIT = 7;

    // Letter glyphs for status text via the raw path.
    localparam logic [7:0] SEG_d     = 8'hA1;
    localparam logic [7:0] SEG_u     = 8'hE3;
    localparam logic [7:0] SEG_minus = 8'hBF;
    localparam logic [7:0] SEG_under = 8'hF7;

    // Per-digit value set, captured on load and committed at frame boundaries.
    typedef struct packed {
        logic [3:0] hex;
        logic [7:0] raw;
        logic       raw_en;
        logic       dp;
        logic       blank;
        logic       blink;
    } digit_cfg_t;

    localparam digit_cfg_t DIGIT_CFG_RESET = '{
        hex:    4'h0,
        raw:    SEG_BLANK,
        raw_en: 1'b0,
        dp:     1'b0,
        blank:  1'b1,
        blink:  1'b0
    };

    typedef enum logic {
        BLINK_SHOW = 1'b0,
        BLINK_HIDE = 1'b1
    } blink_ph_t;

    // Active-low pattern with the decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_led_mux_n_if.sv
// seven_led_mux_n_if: value/strobe inputs and display outputs of the
// seven-segment driver.
//   i_load            capture strobe for all value inputs
//   i_hex/i_raw       per-digit nibble / raw active-low pattern
//   i_raw_en/i_dp     per-digit raw select / decimal point
//   i_blank/i_blink   per-digit dark / blink enable
//   i_bright          on-time level
//   o_seg/o_dig       active-low segments / digit enables
//   o_frame           start-of-frame pulse
interface seven_led_mux_n_if #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned BRIGHT_W = 3
);
    logic                  i_load;
    logic [4*DIGITS-1:0]   i_hex;
    logic [8*DIGITS-1:0]   i_raw;
    logic [DIGITS-1:0]     i_raw_en;
    logic [DIGITS-1:0]     i_dp;
    logic [DIGITS-1:0]     i_blank;
    logic [DIGITS-1:0]     i_blink;
    logic [BRIGHT_W-1:0]   i_bright;
    logic [7:0]            o_seg;
    logic [DIGITS-1:0]     o_dig;
    logic                  o_frame;

    modport master (
        output i_load, i_hex, i_raw, i_raw_en, i_dp, i_blank, i_blink, i_bright,
        input  o_seg, o_dig, o_frame
    );

    modport slave (
        input  i_load, i_hex, i_raw, i_raw_en, i_dp, i_blank, i_blink, i_bright,
        output o_seg, o_dig, o_frame
    );
endinterface

// File: rtl/seven_led_decode.sv
// seven_led_decode: combinational 4-bit to 7-segment decoder.
//   i_hex  nibble to display
//   o_seg  active-low segments g..a (no decimal point)
module seven_led_decode
    import seven_led_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    logic [7:0] full;

    always_comb begin
        full  = hex_to_seg(i_hex);
        o_seg = full[6:0];
    end
endmodule

// File: rtl/seven_led_mux_n.sv
// seven_led_mux_n: multiplexed common-anode seven-segment driver with
// double-buffered values, raw override, dp/blank/blink, PWM brightness
// and an inter-digit guard gap.
//   i_clock    system clock
//   i_reset_n  asynchronous reset, active low
//   bus        value inputs and registered display outputs
module seven_led_mux_n
    import seven_led_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_LOG2    = 14,
    parameter int unsigned GUARD        = 64,
    parameter int unsigned BRIGHT_W     = 3,
    parameter int unsigned BLINK_FRAMES = 256
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    seven_led_mux_n_if.slave  bus
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SCAN_LOG2-1:0]    slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
    logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
    blink_ph_t               blink_ph_q, blink_ph_d;

    digit_cfg_t [DIGITS-1:0] in_cfg;
    digit_cfg_t [DIGITS-1:0] stg_q, stg_d;
    digit_cfg_t [DIGITS-1:0] act_q, act_d;
    logic [BRIGHT_W-1:0]     stg_bright_q, stg_bright_d;
    logic [BRIGHT_W-1:0]     act_bright_q, act_bright_d;

    logic [7:0]              seg_q, seg_d;
    logic [DIGITS-1:0]       dig_q, dig_d;
    logic                    frame_q, frame_d;

    logic                    slot_wrap, dig_wrap, boundary;
    digit_cfg_t              cur;
    logic [6:0]              dec_seg;
    logic [7:0]              pattern;
    logic [BRIGHT_W-1:0]     bright_slice;
    logic                    drive;

    always_comb begin
        in_cfg = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            in_cfg[d].hex    = bus.i_hex[4*d +: 4];
            in_cfg[d].raw    = bus.i_raw[8*d +: 8];
            in_cfg[d].raw_en = bus.i_raw_en[d];
            in_cfg[d].dp     = bus.i_dp[d];
            in_cfg[d].blank  = bus.i_blank[d];
            in_cfg[d].blink  = bus.i_blink[d];
        end
    end

    assign slot_wrap = (slot_cnt_q == '1);
    assign dig_wrap  = (dig_idx_q == IDX_W'(DIGITS - 1));
    assign boundary  = slot_wrap && dig_wrap;

    always_comb begin
        slot_cnt_d  = slot_cnt_q + 1'b1;
        dig_idx_d   = dig_idx_q;
        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (slot_wrap) begin
            dig_idx_d = dig_wrap ? '0 : dig_idx_q + 1'b1;
        end
        if (boundary) begin
            if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_ph_d  = (blink_ph_q == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Commit takes stg_d so a load on the boundary cycle goes straight to active.
    always_comb begin
        stg_d        = bus.i_load ? in_cfg : stg_q;
        stg_bright_d = bus.i_load ? bus.i_bright : stg_bright_q;
        act_d        = boundary ? stg_d : act_q;
        act_bright_d = boundary ? stg_bright_d : act_bright_q;
    end

    assign cur = act_q[dig_idx_q];

    seven_led_decode u_decode (
        .i_hex (cur.hex),
        .o_seg (dec_seg)
    );

    always_comb begin
        pattern      = cur.raw_en ? cur.raw : {~cur.dp, dec_seg};
        bright_slice = slot_cnt_q[SCAN_LOG2-1 -: BRIGHT_W];
        drive        = (slot_cnt_q >= SCAN_LOG2'(GUARD))
                    && (bright_slice <= act_bright_q)
                    && !cur.blank
                    && !(cur.blink && (blink_ph_q == BLINK_HIDE));
        seg_d        = drive ? pattern : SEG_BLANK;
        dig_d        = drive ? ~(DIGITS'(1) << dig_idx_q) : '1;
        frame_d      = (slot_cnt_q == '0) && (dig_idx_q == '0);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            slot_cnt_q   <= '0;
            dig_idx_q    <= '0;
            frame_cnt_q  <= '0;
            blink_ph_q   <= BLINK_SHOW;
            stg_q        <= {DIGITS{DIGIT_CFG_RESET}};
            act_q        <= {DIGITS{DIGIT_CFG_RESET}};
            stg_bright_q <= '1;
            act_bright_q <= '1;
            seg_q        <= SEG_BLANK;
            dig_q        <= '1;
            frame_q      <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            dig_idx_q    <= dig_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_ph_q   <= blink_ph_d;
            stg_q        <= stg_d;
            act_q        <= act_d;
            stg_bright_q <= stg_bright_d;
            act_bright_q <= act_bright_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.o_seg   = seg_q;
    assign bus.o_dig   = dig_q;
    assign bus.o_frame = frame_q;

endmodule
